// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle fetch/decode/execute controller for the accumulator
//            ALU. It fetches 9-bit instructions, decodes them into the ALU
//            opcode and immediate, drives the write strobes and resolves
//            branches. Opcodes 5'h13-5'h1F are undefined and execute as no-ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int         PC_W      = 10,
    parameter logic [8:0] HALT_WORD = 9'h1FF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [8:0]      Instr,
    input  logic            AluZero,
    input  logic [PC_W-1:0] LutTarget,
    output logic [PC_W-1:0] PC,
    output logic            InstRdEn,
    output logic [4:0]      AluOp,
    output logic [4:0]      AluImm,
    output logic [3:0]      RegRdAddr,
    output logic [3:0]      LutIdx,
    output logic            AccWrEn,
    output logic            RegWrEn,
    output logic [3:0]      RegWrAddr,
    output logic            MemRdEn,
    output logic            MemWrEn,
    output logic            Busy,
    output logic            Done
);

    // ALU opcode map shared with the ALU.
    localparam logic [4:0] c_ADD   = 5'h00;
    localparam logic [4:0] c_MOVEA = 5'h0A;
    localparam logic [4:0] c_MOVER = 5'h0B;
    localparam logic [4:0] c_LOAD  = 5'h0C;
    localparam logic [4:0] c_STORE = 5'h0D;
    localparam logic [4:0] c_BEQ   = 5'h0E;
    localparam logic [4:0] c_BNE   = 5'h0F;
    localparam logic [4:0] c_BLE   = 5'h10;
    localparam logic [4:0] c_BLT   = 5'h11;
    localparam logic [4:0] c_JUMP  = 5'h12;

    localparam logic [PC_W-1:0] c_PC_ZERO = '0;
    localparam logic [PC_W-1:0] c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [8:0]      r_ir;
    logic            r_inst_rd;
    logic            r_mem_rd;
    logic            r_mem_wr;
    logic            r_acc_wr;
    logic            r_reg_wr;
    logic            r_done;

    logic [4:0]      w_op;
    logic            w_is_branch;
    logic            w_acc_op;

    assign w_op = r_ir[8:4];

    always_comb begin
        w_is_branch = 1'b0;
        w_acc_op    = 1'b0;
        case (w_op)
            c_BEQ, c_BNE, c_BLE, c_BLT: w_is_branch = 1'b1;
            default: ;
        endcase
        // Arithmetic/logic ops ADD..MOVEA write the accumulator in WB.
        if (w_op >= c_ADD && w_op <= c_MOVEA) begin
            w_acc_op = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= c_PC_ZERO;
            r_ir      <= 9'h000;
            r_inst_rd <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_acc_wr  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_inst_rd <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_acc_wr  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_pc      <= c_PC_ZERO;
                        r_inst_rd <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir <= Instr;
                    if (Instr == HALT_WORD) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_branch) begin
                        r_pc      <= AluZero ? LutTarget : r_pc + c_PC_ONE;
                        r_inst_rd <= 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_op == c_JUMP) begin
                        r_pc      <= LutTarget;
                        r_inst_rd <= 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_op == c_LOAD) begin
                        r_mem_rd <= 1'b1;
                        r_state  <= S_MEM;
                    end else if (w_op == c_STORE) begin
                        r_mem_wr <= 1'b1;
                        r_state  <= S_MEM;
                    end else begin
                        // Undefined opcodes still pass through WB, silently.
                        if (w_op == c_MOVER) begin
                            r_reg_wr <= 1'b1;
                        end else if (w_acc_op) begin
                            r_acc_wr <= 1'b1;
                        end
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_op == c_LOAD) begin
                        r_acc_wr <= 1'b1;
                        r_state  <= S_WB;
                    end else begin
                        r_pc      <= r_pc + c_PC_ONE;
                        r_inst_rd <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_WB: begin
                    r_pc      <= r_pc + c_PC_ONE;
                    r_inst_rd <= 1'b1;
                    r_state   <= S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign PC        = r_pc;
    assign InstRdEn  = r_inst_rd;
    assign AluOp     = r_ir[8:4];
    assign AluImm    = {1'b0, r_ir[3:0]};
    assign RegRdAddr = r_ir[3:0];
    assign LutIdx    = r_ir[3:0];
    assign RegWrAddr = r_ir[3:0];
    assign AccWrEn   = r_acc_wr;
    assign RegWrEn   = r_reg_wr;
    assign MemRdEn   = r_mem_rd;
    assign MemWrEn   = r_mem_wr;
    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    localparam int         PC_W      = 10;
    localparam logic [8:0] HALT_WORD = 9'h1FF;

    localparam logic [4:0] c_ADD   = 5'h00;
    localparam logic [4:0] c_ADDI  = 5'h01;
    localparam logic [4:0] c_MOVER = 5'h0B;
    localparam logic [4:0] c_LOAD  = 5'h0C;
    localparam logic [4:0] c_STORE = 5'h0D;
    localparam logic [4:0] c_BEQ   = 5'h0E;
    localparam logic [4:0] c_JUMP  = 5'h12;
    localparam logic [4:0] c_UNDEF = 5'h13;

    // {InstRdEn, MemRdEn, MemWrEn, AccWrEn, RegWrEn, Busy, Done}
    localparam logic [6:0] c_S_FETCH = 7'b1000010;
    localparam logic [6:0] c_S_BUSY  = 7'b0000010;
    localparam logic [6:0] c_S_MEMRD = 7'b0100010;
    localparam logic [6:0] c_S_MEMWR = 7'b0010010;
    localparam logic [6:0] c_S_ACCWB = 7'b0001010;
    localparam logic [6:0] c_S_REGWB = 7'b0000110;
    localparam logic [6:0] c_S_DONE  = 7'b0000001;
    localparam logic [6:0] c_S_IDLE  = 7'b0000000;

    logic            Clk;
    logic            Reset;
    logic            Start;
    logic [8:0]      Instr;
    logic            AluZero;
    logic [PC_W-1:0] LutTarget;
    logic [PC_W-1:0] PC;
    logic            InstRdEn;
    logic [4:0]      AluOp;
    logic [4:0]      AluImm;
    logic [3:0]      RegRdAddr;
    logic [3:0]      LutIdx;
    logic            AccWrEn;
    logic            RegWrEn;
    logic [3:0]      RegWrAddr;
    logic            MemRdEn;
    logic            MemWrEn;
    logic            Busy;
    logic            Done;

    logic [8:0] imem [0:1023];
    logic [6:0] strb;
    int         nvec;
    int         nmis;

    assign Instr = imem[PC];
    assign strb  = {InstRdEn, MemRdEn, MemWrEn, AccWrEn, RegWrEn, Busy, Done};

    alu_sequencer #(
        .PC_W      (PC_W),
        .HALT_WORD (HALT_WORD)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Instr     (Instr),
        .AluZero   (AluZero),
        .LutTarget (LutTarget),
        .PC        (PC),
        .InstRdEn  (InstRdEn),
        .AluOp     (AluOp),
        .AluImm    (AluImm),
        .RegRdAddr (RegRdAddr),
        .LutIdx    (LutIdx),
        .AccWrEn   (AccWrEn),
        .RegWrEn   (RegWrEn),
        .RegWrAddr (RegWrAddr),
        .MemRdEn   (MemRdEn),
        .MemWrEn   (MemWrEn),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [PC_W-1:0] exp_pc, input logic [6:0] exp_s);
        tick();
        chk({tag, "_pc"}, 32'(PC), 32'(exp_pc));
        chk({tag, "_strb"}, 32'(strb), 32'(exp_s));
    endtask

    initial begin
        nvec      = 0;
        nmis      = 0;
        Reset     = 1'b1;
        Start     = 1'b0;
        AluZero   = 1'b0;
        LutTarget = '0;
        for (int i = 0; i < 1024; i++) imem[i] = HALT_WORD;
        imem[0]      = {c_ADDI, 4'h3};
        imem[1]      = {c_BEQ, 4'h5};
        imem[10'h2A] = {c_BEQ, 4'h6};
        imem[10'h2B] = {c_LOAD, 4'h0};
        imem[10'h2C] = {c_STORE, 4'h0};
        imem[10'h2D] = {c_JUMP, 4'h9};
        imem[10'h3FE] = {c_UNDEF, 4'h0};
        imem[10'h3FF] = {c_MOVER, 4'h7};

        // Reset state
        tick();
        tick();
        chk("reset_pc", 32'(PC), 32'h0);
        chk("reset_strb", 32'(strb), 32'h0);
        chk("reset_aluop", 32'(AluOp), 32'h0);
        chk("reset_regwraddr", 32'(RegWrAddr), 32'h0);
        Reset = 1'b0;

        // ADDI 3 at PC 0
        Start = 1'b1;
        step("addi_fetch", 10'h000, c_S_FETCH);
        Start = 1'b0;
        step("addi_decode", 10'h000, c_S_BUSY);
        step("addi_exec", 10'h000, c_S_BUSY);
        chk("addi_aluop", 32'(AluOp), 32'(c_ADDI));
        chk("addi_aluimm", 32'(AluImm), 32'h03);
        chk("addi_regrd", 32'(RegRdAddr), 32'h3);
        AluZero   = 1'b1;
        LutTarget = 10'h02A;
        step("addi_wb", 10'h000, c_S_ACCWB);

        // BEQ taken; a Start pulse during EXEC must be ignored
        step("beqt_fetch", 10'h001, c_S_FETCH);
        step("beqt_decode", 10'h001, c_S_BUSY);
        step("beqt_exec", 10'h001, c_S_BUSY);
        chk("beqt_lutidx", 32'(LutIdx), 32'h5);
        Start = 1'b1;
        step("beqn_fetch0", 10'h02A, c_S_FETCH);
        Start     = 1'b0;
        AluZero   = 1'b0;
        LutTarget = 10'h155;

        // BEQ not taken
        step("beqn_decode", 10'h02A, c_S_BUSY);
        step("beqn_exec", 10'h02A, c_S_BUSY);
        step("ld_fetch", 10'h02B, c_S_FETCH);

        // LOAD: 5 cycles
        step("ld_decode", 10'h02B, c_S_BUSY);
        step("ld_exec", 10'h02B, c_S_BUSY);
        Start = 1'b1;
        step("ld_mem", 10'h02B, c_S_MEMRD);
        Start = 1'b0;
        step("ld_wb", 10'h02B, c_S_ACCWB);
        step("st_fetch", 10'h02C, c_S_FETCH);

        // STORE: 4 cycles
        step("st_decode", 10'h02C, c_S_BUSY);
        step("st_exec", 10'h02C, c_S_BUSY);
        LutTarget = 10'h3FE;
        step("st_mem", 10'h02C, c_S_MEMWR);

        // JUMP with AluZero low
        step("jmp_fetch", 10'h02D, c_S_FETCH);
        step("jmp_decode", 10'h02D, c_S_BUSY);
        step("jmp_exec", 10'h02D, c_S_BUSY);

        // Undefined opcode acts as no-op
        step("nop_fetch", 10'h3FE, c_S_FETCH);
        step("nop_decode", 10'h3FE, c_S_BUSY);
        step("nop_exec", 10'h3FE, c_S_BUSY);
        step("nop_wb", 10'h3FE, c_S_BUSY);

        // MOVER 7 at the top of the address space, PC wraps to 0
        step("mov_fetch", 10'h3FF, c_S_FETCH);
        step("mov_decode", 10'h3FF, c_S_BUSY);
        step("mov_exec", 10'h3FF, c_S_BUSY);
        imem[0]   = {c_JUMP, 4'h1};
        LutTarget = 10'h005;
        step("mov_wb", 10'h3FF, c_S_REGWB);
        chk("mov_regwraddr", 32'(RegWrAddr), 32'h7);
        step("wrap_fetch", 10'h000, c_S_FETCH);
        step("wrap_decode", 10'h000, c_S_BUSY);
        step("wrap_exec", 10'h000, c_S_BUSY);

        // HALT at PC 5
        step("halt_fetch", 10'h005, c_S_FETCH);
        step("halt_decode", 10'h005, c_S_BUSY);
        step("halt_done", 10'h005, c_S_DONE);
        step("halt_idle", 10'h005, c_S_IDLE);

        // Reset held two cycles during EXEC of an ADD
        imem[0] = {c_ADD, 4'h2};
        Start = 1'b1;
        step("rst_fetch", 10'h000, c_S_FETCH);
        Start = 1'b0;
        step("rst_decode", 10'h000, c_S_BUSY);
        step("rst_exec", 10'h000, c_S_BUSY);
        chk("rst_exec_aluop", 32'(AluOp), 32'(c_ADD));
        Reset = 1'b1;
        step("rst_hold1", 10'h000, c_S_IDLE);
        chk("rst_hold1_aluop", 32'(AluOp), 32'h0);
        chk("rst_hold1_aluimm", 32'(AluImm), 32'h0);
        step("rst_hold2", 10'h000, c_S_IDLE);
        Reset = 1'b0;
        step("rst_after", 10'h000, c_S_IDLE);

        // Reset and Start together: Reset wins
        Reset = 1'b1;
        Start = 1'b1;
        step("rst_vs_start", 10'h000, c_S_IDLE);
        Reset = 1'b0;
        step("restart_fetch", 10'h000, c_S_FETCH);
        Start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire
